fifo_write_arbiter: RTL
=======================

# fifo_write_arbiter

Round-robin arbiter that shares the single write port of the UART TX `Fifo` between `NUM_REQ` producers (e.g. command parser, status reporter, debug echo). Each grant covers a packet or up to `BURST_MAX` words, so a requester's words land in the FIFO contiguously. The arbiter never writes while the FIFO reports `Full`, and the pointer rotation makes starvation impossible. It sits between the producers and the FIFO's `Write`/`WriteData`/`Full` pins.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: data word width; must equal the FIFO `WIDTH`.
- `BURST_MAX`, 4: maximum words accepted per grant, at least 1.
- `Clock`, input, 1: single clock; all state changes on its rising edge.
- `Reset`, input, 1: synchronous, active-high.
- `Req`, input, `NUM_REQ`: requester i holds a valid word.
- `ReqData`, input, `NUM_REQ*WIDTH`: word of requester i at `[i*WIDTH +: WIDTH]`.
- `ReqLast`, input, `NUM_REQ`: requester i's current word ends its packet.
- `Ack`, output, `NUM_REQ`: one-hot or zero; word of requester i is written this cycle.
- `FifoWrite`, output, 1: drives FIFO `Write`.
- `FifoWriteData`, output, `WIDTH`: drives FIFO `WriteData`.
- `FifoFull`, input, 1: from FIFO `Full`.
- `Owner`, output, `$clog2(NUM_REQ)`: index of the current or last grantee.
- `Busy`, output, 1: high while in `GRANT`.

## Operation
- States: `IDLE` and `GRANT`. Registers: `Owner`, `lastOwner`, `burstCnt` (width `$clog2(BURST_MAX+1)`).
- Reset values:
  - state `IDLE`, `Owner`=0, `lastOwner`=`NUM_REQ-1` (requester 0 has first priority), `burstCnt`=0.
  - `Ack`=0, `FifoWrite`=0, `Busy`=0, `FifoWriteData`=`ReqData[0]` (don't-care while `FifoWrite`=0).
- `IDLE`:
  - If any `Req` is set, pick the first set bit scanning upward from `lastOwner+1` modulo `NUM_REQ`.
  - Load that index into `Owner`, clear `burstCnt`, go to `GRANT`.
  - Nothing is written in `IDLE`.
- `GRANT` (combinational outputs):
  - `FifoWrite` = `Req[Owner] & ~FifoFull`.
  - `FifoWriteData` = `ReqData[Owner]`.
  - `Ack` = `FifoWrite << Owner`.
- Accepted word (`FifoWrite`=1): `burstCnt` increments.
- Release: go to `IDLE` and set `lastOwner` = `Owner` when any of these holds:
  - an accepted word has `ReqLast[Owner]`=1;
  - an accepted word makes `burstCnt+1` equal `BURST_MAX`;
  - `Req[Owner]`=0 (the requester withdrew).
- `FifoFull`=1 in `GRANT`: stall. No `Ack`, no count change, grant held; withdrawal still releases.
- `Req` of non-owners is ignored during `GRANT`. Requesters must hold `Req`/`ReqData`/`ReqLast` stable until acked or withdrawn.
- `Reset` mid-grant: next cycle is `IDLE` with reset values. The word presented that cycle is not written.

## Timing
- Arbitration latency is 1 cycle: `Req` seen in `IDLE` at edge n gives `Busy`=1, `Owner` valid, and the first `Ack` possible in cycle n+1.
- Throughput in `GRANT` is 1 word per cycle while `FifoFull`=0.
- Each release costs one `IDLE` bubble cycle. Peak efficiency is `BURST_MAX/(BURST_MAX+1)`.
- `Ack`, `FifoWrite` and `FifoWriteData` are combinational from registered state plus inputs. There is no added pipeline.
- Worst-case wait for a requester holding `Req` high is `(NUM_REQ-1)*(BURST_MAX+1)` writing cycles, excluding FIFO-full stalls.

## Structure
- Package `fifo_arb_pkg` holds:
  - `typedef enum logic {IDLE, GRANT} arb_state_t`;
  - the `$clog2`-derived index width helper.
- Sub-module `rr_pick`: combinational round-robin selector with inputs `Req` and `lastOwner`, outputs `found` and `index`. It is reusable by other UART-side arbiters.
- The top holds the state register, burst counter and output muxing.

## Test plan
All scenarios use `NUM_REQ`=4, `WIDTH`=8, `BURST_MAX`=4, and a `Fifo` of 4 entries.

1. Reset: hold `Reset` 2 cycles with all `Req`=1 → `Ack`=0, `FifoWrite`=0, `Busy`=0 throughout; first grant after release goes to `Owner`=0.
2. Single packet: requester 2 sends 0x11, 0x22, 0x33 with `ReqLast` on 0x33 → three consecutive `Ack`=4'b0100; FIFO reads back 0x11, 0x22, 0x33; `Busy` drops the cycle after 0x33.
3. Burst limit and rotation: requesters 0 and 1 each stream 6 words with no `ReqLast` → write order is 0×4, 1×4, 0×2, 1×2, with one `IDLE` bubble between grants.
4. Full stall: requester 3 sends 6 words, FIFO not read → 4 accepted, `FifoWrite`=0 while `Full`; after one FIFO read, exactly one more word is written (0 lost or duplicated).
5. Withdrawal: requester 1 drops `Req` mid-packet while requesters 2 and 3 wait → release that cycle; next grant goes to `Owner`=2, then 3.
6. Reset mid-grant: assert `Reset` during requester 0's second word → that word is not written; post-reset priority restarts at requester 0.

Source files
------------

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and helpers for the UART TX FIFO write arbiter and its round-robin picker.
package fifo_arb_pkg;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

    // Index width for n items, never below 1 bit so single-entry selects stay legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after last_owner+1, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]        req,
    input  logic [idx_w(N)-1:0] last_owner,
    output logic                found,
    output logic [idx_w(N)-1:0] index
);

    localparam int IDX_W = idx_w(N);

    int best_dist;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path infers a latch.
        found     = 1'b0;
        index     = '0;
        best_dist = N;
        // Distance 0 is the requester right after the last grantee; the smallest distance wins.
        for (int k = 0; k < N; k++) begin
            if (req[k] && (((k + 2 * N - 1 - int'(last_owner)) % N) < best_dist)) begin
                best_dist = (k + 2 * N - 1 - int'(last_owner)) % N;
                found     = 1'b1;
                index     = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO write port; each grant covers one packet or BURST_MAX words.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        Req,
    input  logic [NUM_REQ*WIDTH-1:0]  ReqData,
    input  logic [NUM_REQ-1:0]        ReqLast,
    output logic [NUM_REQ-1:0]        Ack,
    output logic                      FifoWrite,
    output logic [WIDTH-1:0]          FifoWriteData,
    input  logic                      FifoFull,
    output logic [idx_w(NUM_REQ)-1:0] Owner,
    output logic                      Busy
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_owner_q, last_owner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_index;
    logic             owner_req;
    logic             owner_last;
    logic             burst_done;
    logic             release_grant;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req        (Req),
        .last_owner (last_owner_q),
        .found      (pick_found),
        .index      (pick_index)
    );

    assign owner_req  = Req[owner_q];
    assign owner_last = ReqLast[owner_q];
    assign burst_done = (int'(burst_cnt_q) + 1) == BURST_MAX;

    assign Busy          = (state_q == GRANT);
    // Reset gates the write so the word presented in a reset cycle never reaches the FIFO.
    assign FifoWrite     = Busy && !Reset && owner_req && !FifoFull;
    assign FifoWriteData = ReqData[owner_q*WIDTH +: WIDTH];
    assign Ack           = FifoWrite ? (NUM_REQ'(1) << owner_q) : '0;
    assign Owner         = owner_q;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        burst_cnt_d   = burst_cnt_q;
        release_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d     = pick_index;
                    burst_cnt_d = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                // A withdrawal releases even while the FIFO is stalling the grant.
                if (!owner_req) begin
                    release_grant = 1'b1;
                end else if (FifoWrite) begin
                    burst_cnt_d   = burst_cnt_q + CNT_W'(1);
                    release_grant = owner_last || burst_done;
                end
                if (release_grant) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
        if (Reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

endmodule
